// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: two-requester round-robin arbiter driving a 2:1 data mux
// into a registered valid/ready output stage.
//
// Optional feature macro: MUX2_ARB_HOLD_LIMIT_EN
//   defined   - a grant is preempted after MAX_HOLD consecutive beats when the
//               other requester is waiting.
//   undefined - no hold counter; a grant persists until its request drops.
module mux2_rr_arbiter #(
    parameter int DW       = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req,
    input  logic [DW-1:0] din0,
    input  logic [DW-1:0] din1,
    output logic [1:0]    gnt,
    output logic          sel,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          busy
);

    // The hold counter is 4 bits wide, so MAX_HOLD must fit in 1..15.
    if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_max_hold_range_err
        $error("mux2_rr_arbiter: MAX_HOLD must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_last;
    logic [1:0]    r_gnt;
    logic          r_sel;
    logic          r_busy;
    logic [DW-1:0] r_dout;
    logic          r_dout_valid;

    state_t        w_nxt;
    logic          w_cur;
    logic          w_oth;
    logic          w_accept;
    logic          w_xfer;
    logic          w_hold_hit;

    // Index of the requester owning the current grant (only meaningful in GRANTx).
    assign w_cur    = (r_state == GRANT1);
    assign w_oth    = ~w_cur;
    assign w_accept = !r_dout_valid || dout_ready;
    assign w_xfer   = (r_state != IDLE) && req[w_cur] && w_accept;

`ifdef MUX2_ARB_HOLD_LIMIT_EN
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    logic [3:0] r_hold_cnt;

    // Preempt only on the beat that completes the hold window.
    assign w_hold_hit = w_xfer && (r_hold_cnt == HOLD_LAST) && req[w_oth];

    // Beats in the current grant; cleared whenever the state changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt <= 4'd0;
        end else if (w_nxt != r_state) begin
            r_hold_cnt <= 4'd0;
        end else if (w_xfer && (r_hold_cnt != HOLD_LAST)) begin
            r_hold_cnt <= r_hold_cnt + 4'd1;
        end
    end
`else
    assign w_hold_hit = 1'b0;
`endif

    // Next-state decision: release beats preemption, preemption beats staying.
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE: begin
                case (req)
                    2'b01:   w_nxt = GRANT0;
                    2'b10:   w_nxt = GRANT1;
                    2'b11:   w_nxt = r_last ? GRANT0 : GRANT1;
                    default: w_nxt = IDLE;
                endcase
            end
            GRANT0, GRANT1: begin
                if (!req[w_cur]) begin
                    if (req[w_oth]) w_nxt = w_oth ? GRANT1 : GRANT0;
                    else            w_nxt = IDLE;
                end else if (w_hold_hit) begin
                    w_nxt = w_oth ? GRANT1 : GRANT0;
                end
            end
            default: w_nxt = IDLE;
        endcase
    end

    // FSM state, round-robin memory and grant outputs, all registered together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_gnt   <= 2'b00;
            r_sel   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            if (w_nxt != r_state) begin
                if (w_nxt == GRANT0) r_last <= 1'b0;
                if (w_nxt == GRANT1) r_last <= 1'b1;
            end
            case (w_nxt)
                GRANT0: begin
                    r_gnt  <= 2'b01;
                    r_sel  <= 1'b0;
                    r_busy <= 1'b1;
                end
                GRANT1: begin
                    r_gnt  <= 2'b10;
                    r_sel  <= 1'b1;
                    r_busy <= 1'b1;
                end
                default: begin
                    r_gnt  <= 2'b00;
                    r_sel  <= 1'b0;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    // Output stage: capture the muxed beat on a transfer, drain on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else if (w_xfer) begin
            r_dout       <= r_sel ? din1 : din0;
            r_dout_valid <= 1'b1;
        end else if (r_dout_valid && dout_ready) begin
            r_dout_valid <= 1'b0;
        end
    end

    assign gnt        = r_gnt;
    assign sel        = r_sel;
    assign busy       = r_busy;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: directed scenarios followed by
// random traffic, all compared cycle by cycle against a behavioural model.
module tb_mux2_rr_arbiter;
    localparam int DW       = 8;
    localparam int MAX_HOLD = 4;
`ifdef MUX2_ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [1:0]    req;
    logic [DW-1:0] din0, din1;
    logic [1:0]    gnt;
    logic          sel;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          busy;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: owner of the grant (-1 = nobody), last winner,
    // beats delivered in the current grant, and the output register.
    int            m_own;
    bit            m_last;
    int            m_beats;
    logic [DW-1:0] m_dout;
    bit            m_vld;

    mux2_rr_arbiter #(.DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .din0       (din0),
        .din1       (din1),
        .gnt        (gnt),
        .sel        (sel),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs presented in that cycle.
    task automatic model_step(input bit r, input logic [1:0] rq,
                              input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                              input bit rdy);
        int nxt;
        int o;
        bit acc;
        bit xf;
        if (r) begin
            m_own = -1; m_last = 1'b1; m_beats = 0; m_dout = '0; m_vld = 1'b0;
            return;
        end
        acc = !m_vld || rdy;
        xf  = (m_own >= 0) && rq[m_own] && acc;
        if (xf) begin
            m_dout = (m_own == 1) ? d1 : d0;
            m_vld  = 1'b1;
            m_beats++;
        end else if (m_vld && rdy) begin
            m_vld = 1'b0;
        end
        if (m_own < 0) begin
            if (rq == 2'b11)      nxt = m_last ? 0 : 1;
            else if (rq == 2'b01) nxt = 0;
            else if (rq == 2'b10) nxt = 1;
            else                  nxt = -1;
        end else begin
            o = 1 - m_own;
            if (!rq[m_own])                                          nxt = rq[o] ? o : -1;
            else if (HOLD_EN && xf && m_beats >= MAX_HOLD && rq[o])  nxt = o;
            else                                                     nxt = m_own;
        end
        if (nxt != m_own) begin
            m_beats = 0;
            if (nxt >= 0) m_last = (nxt == 1);
        end
        m_own = nxt;
    endtask

    task automatic check_all();
        logic [1:0] eg;
        eg = (m_own == 0) ? 2'b01 : (m_own == 1) ? 2'b10 : 2'b00;
        chk("gnt",        gnt,        eg);
        chk("sel",        sel,        (m_own == 1));
        chk("busy",       busy,       (m_own >= 0));
        chk("dout_valid", dout_valid, m_vld);
        chk("dout",       dout,       m_dout);
    endtask

    // Present inputs for one cycle, advance the model, check after the edge.
    task automatic cyc(input bit r, input logic [1:0] rq,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1, input bit rdy);
        rst = r; req = rq; din0 = d0; din1 = d1; dout_ready = rdy;
        model_step(r, rq, d0, d1, rdy);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [DW-1:0] held;
        logic [DW-1:0] d0, d1;
        logic [1:0]    rq;
        bit            rr, rdy;

        // Reset with both requests high: nothing granted, output empty.
        cyc(1, 2'b11, 8'h11, 8'h22, 1);
        chk("rst_gnt", gnt, 2'b00);
        cyc(1, 2'b11, 8'h11, 8'h22, 1);
        chk("rst_dv", dout_valid, 1'b0);
        chk("rst_dout", dout, '0);
        cyc(0, 2'b11, 8'h11, 8'h22, 1);
        chk("first_gnt", gnt, 2'b01);
        repeat (3) cyc(0, 2'b00, 8'h00, 8'h00, 1);

        // Single requester 0.
        cyc(0, 2'b01, 8'hA5, 8'h00, 1);
        chk("single_gnt", gnt, 2'b01);
        cyc(0, 2'b01, 8'hA5, 8'h00, 1);
        chk("single_dout", dout, 8'hA5);
        chk("single_dv", dout_valid, 1'b1);
        chk("single_sel", sel, 1'b0);
        repeat (3) cyc(0, 2'b00, 8'h00, 8'h00, 1);

        // Both requesting continuously: hold-limit preemption when enabled.
        for (int i = 0; i < 24; i++) cyc(0, 2'b11, 8'(8'h40 + i), 8'(8'hC0 + i), 1);
        repeat (3) cyc(0, 2'b00, 8'h00, 8'h00, 1);

        // Backpressure while requester 1 streams.
        for (int i = 0; i < 3; i++) cyc(0, 2'b10, 8'h00, 8'(8'h70 + i), 1);
        chk("bp_gnt", gnt, 2'b10);
        held = dout;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 2'b10, 8'h00, 8'h7F, 0);
            chk("bp_dout", dout, held);
            chk("bp_dv", dout_valid, 1'b1);
        end
        cyc(0, 2'b10, 8'h00, 8'h7F, 1);
        chk("bp_resume", dout, 8'h7F);
        for (int i = 0; i < 3; i++) cyc(0, 2'b10, 8'h00, 8'(8'h80 + i), 1);

        // Release handoff GRANT0 -> GRANT1, then tie from IDLE goes to 0.
        cyc(0, 2'b01, 8'h31, 8'h00, 1);
        cyc(0, 2'b01, 8'h32, 8'h00, 1);
        chk("ho_gnt0", gnt, 2'b01);
        cyc(0, 2'b10, 8'h00, 8'h55, 1);
        chk("ho_gnt1", gnt, 2'b10);
        repeat (3) cyc(0, 2'b00, 8'h00, 8'h00, 1);
        cyc(0, 2'b11, 8'h12, 8'h34, 1);
        chk("ho_tie", gnt, 2'b01);
        repeat (3) cyc(0, 2'b00, 8'h00, 8'h00, 1);

        // Mid-stream reset with a beat pending.
        cyc(0, 2'b01, 8'hE1, 8'h00, 0);
        cyc(0, 2'b01, 8'hE2, 8'h00, 0);
        chk("mr_dv_pre", dout_valid, 1'b1);
        cyc(1, 2'b01, 8'hE3, 8'h00, 0);
        chk("mr_dv", dout_valid, 1'b0);
        chk("mr_gnt", gnt, 2'b00);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 2'b00, 8'h00, 8'h00, 1);
            chk("mr_no_beat", dout_valid, 1'b0);
        end

        // Random traffic with sticky requests and occasional resets.
        rq = 2'b00;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) rq[0] = ~rq[0];
            if ($urandom_range(0, 3) == 0) rq[1] = ~rq[1];
            d0  = 8'($urandom);
            d1  = 8'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            rr  = ($urandom_range(0, 99) == 0);
            cyc(rr, rq, d0, d1, rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
